result_serializer: RTL and testbench
====================================

RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, result-memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, result word width.
REQ-003 SHALL have port iClock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port iReset_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port iStart  input  1  level request to begin a readout of result memory.
REQ-006 SHALL have port iNumWords  input  16  number of words to send; sampled only at start.
REQ-007 SHALL have port oMemAddr  output  ADDR_WIDTH  registered read address to the result memory port.
REQ-008 SHALL have port iMemReadData  input  DATA_WIDTH  memory read data; valid one cycle after oMemAddr.
REQ-009 SHALL have port oSerialData  output  DATA_WIDTH  current word presented to the HPS PIO.
REQ-010 SHALL have port oSerialIndex  output  32  index of the word on oSerialData.
REQ-011 SHALL have port oDataValid  output  1  oSerialData and oSerialIndex are stable and readable.
REQ-012 SHALL have port iDataTaken  input  1  HPS acknowledge, four-phase level.
REQ-013 SHALL have port oBusy  output  1  readout in progress.
REQ-014 SHALL have port oDone  output  1  all words delivered.
REQ-015 SHALL have port iDoneFeedback  input  1  HPS has seen oDone.

Function
REQ-016 SHALL implement the states IDLE, READ, CAPTURE, PRESENT, WAIT_ACK_LOW and DONE.
REQ-017 In IDLE with iStart=1, SHALL latch the word count and set index=0 and oMemAddr=0.
- Latched count = min(iNumWords, 2^ADDR_WIDTH).
- Next state: READ if count>0; DONE if count=0.
REQ-018 READ SHALL last exactly one cycle, then go to CAPTURE, allowing for the 1-cycle memory latency.
REQ-019 CAPTURE SHALL register iMemReadData into oSerialData and index into oSerialIndex, set oDataValid=1, then go to PRESENT.
REQ-020 First-word latency: oDataValid SHALL first be high 3 cycles after the cycle iStart is sampled in IDLE.
REQ-021 PRESENT SHALL hold oSerialData, oSerialIndex and oDataValid=1 stable until iDataTaken=1 is sampled.
- On that sample: oDataValid SHALL clear on the next cycle, and the state SHALL go to WAIT_ACK_LOW.
REQ-022 WAIT_ACK_LOW SHALL keep oDataValid=0 until iDataTaken=0 is sampled, then act on index.
- If index+1 < count: increment index and oMemAddr, go to READ.
- Otherwise: go to DONE.
REQ-023 Inter-word latency: oDataValid SHALL rise 3 cycles after iDataTaken=0 is sampled in WAIT_ACK_LOW.
REQ-024 Four-phase ordering SHALL be enforced: no word advances while iDataTaken stays high, and no word is skipped or repeated.
REQ-025 DONE SHALL hold oDone=1 and oBusy=0 until iDoneFeedback=1 is sampled, then return to IDLE.
REQ-026 On return to IDLE, the block SHALL NOT restart while iStart remains high.
- A new readout requires iStart sampled low then high.
REQ-027 oBusy SHALL be 1 in READ, CAPTURE, PRESENT and WAIT_ACK_LOW, and 0 in IDLE and DONE.
REQ-028 iStart changes outside IDLE SHALL be ignored; iNumWords changes after latching SHALL have no effect.
REQ-029 iDataTaken=1 while in IDLE, READ or CAPTURE SHALL be ignored and SHALL NOT be counted as an acknowledge.
REQ-030 The index counter SHALL be wide enough for 2^ADDR_WIDTH, and oMemAddr SHALL NOT wrap within a readout.
REQ-031 iDoneFeedback outside DONE SHALL be ignored.

Reset
REQ-032 With iReset_n=0 at a rising edge, the block SHALL enter IDLE on the next cycle and set every output to 0.
- Outputs: oMemAddr, oSerialData, oSerialIndex, oDataValid, oBusy, oDone.
- Internal index and count SHALL also be 0.
REQ-033 Reset mid-readout SHALL abandon the transfer with no further oDataValid pulses.
- After release, the block SHALL wait for a fresh iStart low-to-high sequence.
REQ-034 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-035 Basic readout: memory[i]=0xA000_0000+i, iNumWords=4, HPS acks each word after 5 cycles.
- Required: words 0xA0000000 to 0xA0000003 with oSerialIndex 0 to 3, each exactly once.
- Required: first oDataValid 3 cycles after iStart; oDone=1 after the 4th iDataTaken falls.
REQ-036 Zero count: iNumWords=0, iStart=1 -> oDone=1 next cycle, oDataValid never asserts, oMemAddr stays 0.
REQ-037 Held acknowledge: iDataTaken held high 50 cycles on word 1 -> oDataValid=0 throughout, index stays 1.
- Word 2 appears 3 cycles after iDataTaken falls.
REQ-038 Saturation: ADDR_WIDTH=4, iNumWords=100 -> exactly 16 words (indices 0 to 15), then oDone.
REQ-039 Reset mid-operation: iReset_n=0 during PRESENT of word 2 of 8 -> all outputs 0 next cycle.
- Required: no activity while iStart stays high; a new iStart pulse restarts at index 0.
REQ-040 Restart protection: iStart held high through iDoneFeedback -> remains in IDLE with oBusy=0.
- Required: iStart toggling low then high starts a second readout.

Source files
------------

// File: rtl/result_serializer.sv
// result_serializer: reads a block of result memory one word at a time and
// presents each word to the HPS PIO with a four-phase valid/taken handshake.
module result_serializer #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  iClock,
   input  logic                  iReset_n,
   input  logic                  iStart,
   input  logic [15:0]           iNumWords,
   output logic [ADDR_WIDTH-1:0] oMemAddr,
   input  logic [DATA_WIDTH-1:0] iMemReadData,
   output logic [DATA_WIDTH-1:0] oSerialData,
   output logic [31:0]           oSerialIndex,
   output logic                  oDataValid,
   input  logic                  iDataTaken,
   output logic                  oBusy,
   output logic                  oDone,
   input  logic                  iDoneFeedback
);

   // Count/index must hold 2^ADDR_WIDTH as well as any 16-bit request.
   localparam int unsigned CNT_W = (ADDR_WIDTH + 1 > 16) ? ADDR_WIDTH + 1 : 16;
   localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'({1'b1, {ADDR_WIDTH{1'b0}}});

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      READ         = 3'd1,
      CAPTURE      = 3'd2,
      PRESENT      = 3'd3,
      WAIT_ACK_LOW = 3'd4,
      DONE         = 3'd5
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] index;
   logic [CNT_W-1:0] count;
   logic             armed;
   logic [CNT_W-1:0] req_words;
   logic [CNT_W-1:0] next_index;

   // Requested word count clamped to the memory depth, and the next index.
   always_comb begin
      req_words  = CNT_W'(iNumWords);
      next_index = index + CNT_W'(1);
      if (req_words > MAX_WORDS) begin
         req_words = MAX_WORDS;
      end
   end

   // Readout state machine; every output is registered here.
   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         state        <= IDLE;
         index        <= '0;
         count        <= '0;
         armed        <= 1'b0;
         oMemAddr     <= '0;
         oSerialData  <= '0;
         oSerialIndex <= '0;
         oDataValid   <= 1'b0;
         oBusy        <= 1'b0;
         oDone        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A start needs iStart seen low in IDLE first, so a level
               // held over from a previous readout or reset cannot retrigger.
               if (!iStart) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  armed    <= 1'b0;
                  count    <= req_words;
                  index    <= '0;
                  oMemAddr <= '0;
                  if (req_words != '0) begin
                     state <= READ;
                     oBusy <= 1'b1;
                  end else begin
                     state <= DONE;
                     oDone <= 1'b1;
                  end
               end
            end
            READ: begin
               // Address was issued on entry; wait out the memory latency.
               state <= CAPTURE;
            end
            CAPTURE: begin
               oSerialData  <= iMemReadData;
               oSerialIndex <= 32'(index);
               oDataValid   <= 1'b1;
               state        <= PRESENT;
            end
            PRESENT: begin
               if (iDataTaken) begin
                  oDataValid <= 1'b0;
                  state      <= WAIT_ACK_LOW;
               end
            end
            WAIT_ACK_LOW: begin
               if (!iDataTaken) begin
                  if (next_index < count) begin
                     index    <= next_index;
                     oMemAddr <= ADDR_WIDTH'(next_index);
                     state    <= READ;
                  end else begin
                     oBusy <= 1'b0;
                     oDone <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (iDoneFeedback) begin
                  oDone <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               oDataValid <= 1'b0;
               oBusy      <= 1'b0;
               oDone      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: synchronous memory model, HPS handshake driver,
// and a scoreboard of expected words checked against words seen on the PIO.
module tb_result_serializer;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [15:0]   num_words;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd;
   logic [DW-1:0] ser_data;
   logic [31:0]   ser_idx;
   logic          valid;
   logic          taken;
   logic          busy;
   logic          done;
   logic          done_fb;

   logic [DW-1:0] mem [16];
   int            cyc = 0;
   int            tests_run = 0;
   int            tests_failed = 0;
   logic          prev_valid = 1'b0;

   typedef struct {
      logic [31:0] data;
      logic [31:0] idx;
      int          cyc;
   } rec_t;

   rec_t got_q[$];
   rec_t exp_q[$];

   result_serializer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .iClock        (clk),
      .iReset_n      (rst_n),
      .iStart        (start),
      .iNumWords     (num_words),
      .oMemAddr      (mem_addr),
      .iMemReadData  (mem_rd),
      .oSerialData   (ser_data),
      .oSerialIndex  (ser_idx),
      .oDataValid    (valid),
      .iDataTaken    (taken),
      .oBusy         (busy),
      .oDone         (done),
      .iDoneFeedback (done_fb)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      mem_rd <= mem[mem_addr];
   end

   // Record every rising edge of valid with the word, index and edge count.
   always @(negedge clk) begin
      if (valid === 1'b1 && prev_valid !== 1'b1) begin
         got_q.push_back('{data: ser_data, idx: ser_idx, cyc: cyc});
      end
      prev_valid = valid;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [31:0] d, input int i);
      exp_q.push_back('{data: d, idx: 32'(i), cyc: 0});
   endtask

   task automatic start_readout(input logic [15:0] n, output int st);
      num_words = n;
      start     = 1'b1;
      st        = cyc;
   endtask

   // HPS side: wait for valid, ack after delay, release once valid drops.
   task automatic hps_take(input int delay, output bit ok, output int fall);
      int n;
      ok = 1'b0;
      fall = 0;
      n = 0;
      while (valid !== 1'b1 && n < 100) begin
         tick(1);
         n++;
      end
      if (valid !== 1'b1) return;
      tick(delay);
      taken = 1'b1;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (valid !== 1'b0 && n < 100);
      taken = 1'b0;
      if (valid !== 1'b0) return;
      fall = cyc;
      ok = 1'b1;
   endtask

   task automatic finish_readout();
      start   = 1'b0;
      done_fb = 1'b1;
      tick(1);
      done_fb = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; num_words = '0; taken = 1'b0; done_fb = 1'b0;
      tick(3);
      tests_run++;
      if ({mem_addr, ser_data, ser_idx, valid, busy, done} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: addr=%0h data=%0h idx=%0d valid=%b busy=%b done=%b, required all 0",
                  mem_addr, ser_data, ser_idx, valid, busy, done);
      end
      rst_n = 1'b1;
      tick(2);
      got_q.delete();
   endtask

   task automatic test_basic();
      int st, fall[4];
      bit ok;
      for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < 4; i++) push_exp(mem[i], i);
      start_readout(16'd4, st);
      tick(1);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_busy: busy=%b, required 1", busy);
      end
      for (int i = 0; i < 4; i++) begin
         hps_take(5, ok, fall[i]);
         tests_run++;
         if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_handshake_timeout: word %0d not delivered", i);
         end
      end
      tests_run++;
      if (got_q.size() < 4 || got_q[0].cyc !== st + 3) begin
         tests_failed++;
         $display("FAIL basic_first_latency: got %0d, required %0d",
                  (got_q.size() > 0) ? got_q[0].cyc - st : -1, 3);
      end
      tests_run++;
      if (got_q.size() < 4 || got_q[1].cyc !== fall[0] + 3) begin
         tests_failed++;
         $display("FAIL basic_inter_latency: got %0d, required %0d",
                  (got_q.size() > 1) ? got_q[1].cyc - fall[0] : -1, 3);
      end
      tick(1);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_done: done=%b busy=%b, required done=1 busy=0", done, busy);
      end
      while (exp_q.size() > 0) begin
         rec_t e, r;
         e = exp_q.pop_front();
         tests_run++;
         if (got_q.size() == 0) begin
            tests_failed++;
            $display("FAIL basic_word: index %0d missing, required %08h", e.idx, e.data);
         end else begin
            r = got_q.pop_front();
            if (r.data !== e.data || r.idx !== e.idx) begin
               tests_failed++;
               $display("FAIL basic_word: got %08h/%0d, required %08h/%0d", r.data, r.idx, e.data, e.idx);
            end
         end
      end
      tests_run++;
      if (got_q.size() != 0) begin
         tests_failed++;
         $display("FAIL basic_extra_words: got %0d extra, required 0", got_q.size());
      end
      finish_readout();
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_done_clear: done=%b, required 0", done);
      end
      got_q.delete();
   endtask

   task automatic test_zero_count();
      int st;
      start_readout(16'd0, st);
      tick(1);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0 || mem_addr !== '0) begin
         tests_failed++;
         $display("FAIL zero_done: done=%b busy=%b addr=%0d, required 1/0/0", done, busy, mem_addr);
      end
      tick(5);
      tests_run++;
      if (got_q.size() != 0 || mem_addr !== '0 || valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_no_words: words=%0d addr=%0d valid=%b, required 0/0/0", got_q.size(), mem_addr, valid);
      end
      finish_readout();
      got_q.delete();
   endtask

   task automatic test_held_ack();
      int st, fc, fall;
      int n;
      bit ok, bad;
      for (int i = 0; i < 16; i++) mem[i] = 32'h1100_0000 + 32'(i);
      for (int i = 0; i < 4; i++) push_exp(mem[i], i);
      start_readout(16'd4, st);
      hps_take(2, ok, fall);
      n = 0;
      while (valid !== 1'b1 && n < 100) begin tick(1); n++; end
      tests_run++;
      if (valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL held_word1_timeout: valid=%b, required 1", valid);
      end
      taken = 1'b1;
      tick(1);
      bad = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (valid !== 1'b0 || ser_idx !== 32'd1) bad = 1'b1;
         tick(1);
      end
      tests_run++;
      if (bad !== 1'b0 || got_q.size() != 2) begin
         tests_failed++;
         $display("FAIL held_stall: glitch=%b words=%0d, required 0/2", bad, got_q.size());
      end
      taken = 1'b0;
      fc = cyc;
      hps_take(1, ok, fall);
      hps_take(3, ok, fall);
      tests_run++;
      if (got_q.size() < 3 || got_q[2].cyc !== fc + 3) begin
         tests_failed++;
         $display("FAIL held_resume_latency: got %0d, required %0d",
                  (got_q.size() > 2) ? got_q[2].cyc - fc : -1, 3);
      end
      tick(1);
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("FAIL held_done: done=%b, required 1", done);
      end
      while (exp_q.size() > 0) begin
         rec_t e, r;
         e = exp_q.pop_front();
         tests_run++;
         if (got_q.size() == 0) begin
            tests_failed++;
            $display("FAIL held_word: index %0d missing, required %08h", e.idx, e.data);
         end else begin
            r = got_q.pop_front();
            if (r.data !== e.data || r.idx !== e.idx) begin
               tests_failed++;
               $display("FAIL held_word: got %08h/%0d, required %08h/%0d", r.data, r.idx, e.data, e.idx);
            end
         end
      end
      finish_readout();
      got_q.delete();
   endtask

   task automatic test_early_ack();
      int st, fall;
      bit ok;
      for (int i = 0; i < 16; i++) mem[i] = 32'h3300_0000 + 32'(i);
      for (int i = 0; i < 2; i++) push_exp(mem[i], i);
      start_readout(16'd2, st);
      taken = 1'b1;
      tick(1);
      num_words = 16'd9;
      done_fb   = 1'b1;
      tick(2);
      taken   = 1'b0;
      done_fb = 1'b0;
      tick(3);
      tests_run++;
      if (valid !== 1'b1 || ser_idx !== 32'd0) begin
         tests_failed++;
         $display("FAIL early_ack_ignored: valid=%b idx=%0d, required 1/0", valid, ser_idx);
      end
      for (int i = 0; i < 2; i++) hps_take(0, ok, fall);
      tick(1);
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("FAIL early_done: done=%b, required 1", done);
      end
      while (exp_q.size() > 0) begin
         rec_t e, r;
         e = exp_q.pop_front();
         tests_run++;
         if (got_q.size() == 0) begin
            tests_failed++;
            $display("FAIL early_word: index %0d missing, required %08h", e.idx, e.data);
         end else begin
            r = got_q.pop_front();
            if (r.data !== e.data || r.idx !== e.idx) begin
               tests_failed++;
               $display("FAIL early_word: got %08h/%0d, required %08h/%0d", r.data, r.idx, e.data, e.idx);
            end
         end
      end
      tests_run++;
      if (got_q.size() != 0) begin
         tests_failed++;
         $display("FAIL early_count_latched: got %0d extra words, required 0", got_q.size());
      end
      finish_readout();
      got_q.delete();
   endtask

   task automatic test_saturation();
      int st, fall;
      bit ok;
      for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 3);
      for (int i = 0; i < 16; i++) push_exp(mem[i], i);
      start_readout(16'd100, st);
      for (int i = 0; i < 16; i++) begin
         hps_take(int'($urandom_range(0, 3)), ok, fall);
         tests_run++;
         if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_handshake_timeout: word %0d not delivered", i);
         end
      end
      tick(1);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_done: done=%b busy=%b, required 1/0", done, busy);
      end
      tick(5);
      while (exp_q.size() > 0) begin
         rec_t e, r;
         e = exp_q.pop_front();
         tests_run++;
         if (got_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sat_word: index %0d missing, required %08h", e.idx, e.data);
         end else begin
            r = got_q.pop_front();
            if (r.data !== e.data || r.idx !== e.idx) begin
               tests_failed++;
               $display("FAIL sat_word: got %08h/%0d, required %08h/%0d", r.data, r.idx, e.data, e.idx);
            end
         end
      end
      tests_run++;
      if (got_q.size() != 0) begin
         tests_failed++;
         $display("FAIL sat_extra_words: got %0d extra, required 0", got_q.size());
      end
      finish_readout();
      got_q.delete();
   endtask

   task automatic test_reset_mid();
      int st, fall, n;
      bit ok;
      for (int i = 0; i < 16; i++) mem[i] = 32'h7700_0000 + 32'(i);
      for (int i = 0; i < 3; i++) push_exp(mem[i], i);
      start_readout(16'd8, st);
      hps_take(1, ok, fall);
      hps_take(1, ok, fall);
      n = 0;
      while (valid !== 1'b1 && n < 100) begin tick(1); n++; end
      rst_n = 1'b0;
      tick(1);
      tests_run++;
      if ({mem_addr, ser_data, ser_idx, valid, busy, done} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: addr=%0h data=%0h idx=%0d valid=%b busy=%b done=%b, required all 0",
                  mem_addr, ser_data, ser_idx, valid, busy, done);
      end
      rst_n = 1'b1;
      tick(10);
      tests_run++;
      if (busy !== 1'b0 || valid !== 1'b0 || got_q.size() != 3) begin
         tests_failed++;
         $display("FAIL midreset_quiet: busy=%b valid=%b words=%0d, required 0/0/3", busy, valid, got_q.size());
      end
      while (exp_q.size() > 0) begin
         rec_t e, r;
         e = exp_q.pop_front();
         tests_run++;
         if (got_q.size() == 0) begin
            tests_failed++;
            $display("FAIL midreset_word: index %0d missing, required %08h", e.idx, e.data);
         end else begin
            r = got_q.pop_front();
            if (r.data !== e.data || r.idx !== e.idx) begin
               tests_failed++;
               $display("FAIL midreset_word: got %08h/%0d, required %08h/%0d", r.data, r.idx, e.data, e.idx);
            end
         end
      end
      got_q.delete();
      start = 1'b0;
      tick(1);
      for (int i = 0; i < 2; i++) push_exp(mem[i], i);
      start_readout(16'd2, st);
      hps_take(0, ok, fall);
      hps_take(0, ok, fall);
      tests_run++;
      if (got_q.size() == 0 || got_q[0].cyc !== st + 3) begin
         tests_failed++;
         $display("FAIL restart_latency: got %0d, required %0d",
                  (got_q.size() > 0) ? got_q[0].cyc - st : -1, 3);
      end
      while (exp_q.size() > 0) begin
         rec_t e, r;
         e = exp_q.pop_front();
         tests_run++;
         if (got_q.size() == 0) begin
            tests_failed++;
            $display("FAIL restart_word: index %0d missing, required %08h", e.idx, e.data);
         end else begin
            r = got_q.pop_front();
            if (r.data !== e.data || r.idx !== e.idx) begin
               tests_failed++;
               $display("FAIL restart_word: got %08h/%0d, required %08h/%0d", r.data, r.idx, e.data, e.idx);
            end
         end
      end
      tick(1);
      finish_readout();
      got_q.delete();
   endtask

   task automatic test_restart_protect();
      int st, fall;
      bit ok;
      for (int i = 0; i < 16; i++) mem[i] = 32'hBEEF_0000 + 32'(i);
      start_readout(16'd1, st);
      hps_take(0, ok, fall);
      tick(1);
      done_fb = 1'b1;
      tick(1);
      done_fb = 1'b0;
      tick(10);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 || got_q.size() != 1) begin
         tests_failed++;
         $display("FAIL protect_idle: busy=%b done=%b valid=%b words=%0d, required 0/0/0/1",
                  busy, done, valid, got_q.size());
      end
      got_q.delete();
      start = 1'b0;
      tick(1);
      push_exp(mem[0], 0);
      start_readout(16'd1, st);
      hps_take(0, ok, fall);
      tests_run++;
      if (ok !== 1'b1 || got_q.size() != 1 || got_q[0].cyc !== st + 3 ||
          got_q[0].data !== exp_q[0].data || got_q[0].idx !== exp_q[0].idx) begin
         tests_failed++;
         $display("FAIL protect_second_readout: ok=%b words=%0d, required 1 word %08h index 0 at latency 3",
                  ok, got_q.size(), exp_q[0].data);
      end
      exp_q.delete();
      tick(1);
      finish_readout();
      got_q.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_held_ack();
      test_early_ack();
      test_saturation();
      test_reset_mid();
      test_restart_protect();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
